bsg_chip_unswizzle_link_rx: RTL and testbench

- Receive-side endpoint for one comm-link channel whose pins were permuted by the transmit-side swizzle adapter on the neighbouring chip.
- Registers the incoming pin bundle and restores the logical valid/data order per the selected swizzle mode.
- Buffers words in a small FIFO and presents them to bsg_chip_guts with a valid/ready handshake.
- Returns flow-control credits to the sender on a toggling token line.

---
 rtl/bsg_chip_unswizzle_link_rx.sv | 132 +++++++++++++
 tb/tb_bsg_chip_unswizzle_link_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_unswizzle_link_rx.sv
// Receive endpoint for one comm-link channel whose pins were permuted by the
// transmit-side swizzle adapter. The pins are registered, the logical
// valid/data order is restored, and the words are buffered in a small FIFO
// that guts drains with valid/ready. Credits go back to the sender as edges
// on a toggling token line.
//
// Handshake: a word moves from this block to guts on every rising clk_i edge
// where v_o & ready_i is high. v_o never depends on ready_i, and data_o holds
// its value while v_o & !ready_i.
module bsg_chip_unswizzle_link_rx #(
  parameter int swizzle_mode_p         = 0,
  parameter int fifo_els_p             = 8,
  parameter int lg_credit_decimation_p = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                port_v_i,
  input  logic [8:0]                          port_data_i,
  output logic                                port_tkn_o,
  output logic                                v_o,
  output logic [8:0]                          data_o,
  input  logic                                ready_i,
  output logic                                overflow_o,
  output logic [$clog2(fifo_els_p+1)-1:0]     occupancy_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = (lg_credit_decimation_p > 0) ? lg_credit_decimation_p : 1;

  // Reject parameter sets that cannot be built correctly.
  if (swizzle_mode_p < 0 || swizzle_mode_p > 2) begin : g_bad_mode
    $error("bsg_chip_unswizzle_link_rx: swizzle_mode_p must be 0, 1 or 2");
  end
  // A single-entry buffer would have no pointer bits, so depth 1 is refused too.
  if (fifo_els_p < 2 || (fifo_els_p & (fifo_els_p - 1)) != 0) begin : g_bad_depth
    $error("bsg_chip_unswizzle_link_rx: fifo_els_p must be a power of 2 and at least 2");
  end
  if (fifo_els_p < (1 << lg_credit_decimation_p)) begin : g_bad_decim
    $error("bsg_chip_unswizzle_link_rx: fifo_els_p must cover one credit batch");
  end

  logic [9:0]          in_r;
  logic                pin_v;
  logic [8:0]          pin_d;
  logic                un_v;
  logic [8:0]          un_d;
  logic [ptr_w_lp:0]   wptr_r;
  logic [ptr_w_lp:0]   rptr_r;
  logic [8:0]          mem_r [fifo_els_p];
  logic                empty;
  logic                full;
  logic                enq;
  logic                deq;
  logic                overflow_r;
  logic [cnt_w_lp-1:0] credit_cnt_r;
  logic                credit_wrap;
  logic                tkn_r;

  // Stage 1: capture the raw pin bundle every cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) in_r <= '0;
    else         in_r <= {port_v_i, port_data_i};
  end

  assign pin_v = in_r[9];
  assign pin_d = in_r[8:0];

  // Stage 2: undo the transmit-side pin permutation.
  always_comb begin
    un_v = 1'b0;
    un_d = '0;
    if (swizzle_mode_p == 1) begin
      un_v = pin_d[5];
      un_d = {pin_d[3], pin_d[2], pin_d[0], pin_d[1], pin_v,
              pin_d[4], pin_d[6], pin_d[7], pin_d[8]};
    end else if (swizzle_mode_p == 2) begin
      un_v = pin_d[2];
      un_d = {pin_d[0], pin_d[1], pin_d[3], pin_d[4], pin_v,
              pin_d[5], pin_d[6], pin_d[7], pin_d[8]};
    end else begin
      un_v = pin_v;
      un_d = pin_d;
    end
  end

  // The wrap bit (pointer MSB) separates full from empty when indices match.
  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]) &&
                 (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]);
  assign deq   = !empty && ready_i;
  // A same-cycle dequeue frees the slot a full FIFO needs for this enqueue.
  assign enq   = un_v && (!full || deq);

  // Pointer and sticky overflow update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (enq) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
      if (deq) rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
      if (un_v && full && !deq) overflow_r <= 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[ptr_w_lp-1:0]] <= un_d;
  end

  assign credit_wrap = (lg_credit_decimation_p == 0) ? 1'b1 : (&credit_cnt_r);

  // Count dequeues; each full batch flips the token line.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credit_cnt_r <= '0;
      tkn_r        <= 1'b0;
    end else if (deq) begin
      credit_cnt_r <= credit_cnt_r + cnt_w_lp'(1);
      if (credit_wrap) tkn_r <= ~tkn_r;
    end
  end

  assign v_o         = !empty;
  // Forced to zero when empty so data_o is defined straight out of reset.
  assign data_o      = empty ? 9'h000 : mem_r[rptr_r[ptr_w_lp-1:0]];
  assign occupancy_o = wptr_r - rptr_r;
  assign overflow_o  = overflow_r;
  assign port_tkn_o  = tkn_r;

endmodule

// File: tb/tb_bsg_chip_unswizzle_link_rx.sv
// Bench for bsg_chip_unswizzle_link_rx: one instance per swizzle mode
// (index = mode), a queue-based scoreboard per instance fed when pins are
// driven, and a negedge monitor that checks head data and token state.
module tb_bsg_chip_unswizzle_link_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       pv   [3];
  logic [8:0] pd   [3];
  logic       rdy  [3];
  logic       tkn  [3];
  logic       vo   [3];
  logic [8:0] dout [3];
  logic       ovf  [3];
  logic [3:0] occ  [3];

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];
  int         deq_cnt [3];
  logic       exp_tkn [3];
  int         tests_run    = 0;
  int         tests_failed = 0;

  // Clock and DUTs
  always #5 clk = ~clk;

  bsg_chip_unswizzle_link_rx #(.swizzle_mode_p(0)) u_m0 (
    .clk_i(clk), .reset_i(rst), .port_v_i(pv[0]), .port_data_i(pd[0]),
    .port_tkn_o(tkn[0]), .v_o(vo[0]), .data_o(dout[0]), .ready_i(rdy[0]),
    .overflow_o(ovf[0]), .occupancy_o(occ[0]));

  bsg_chip_unswizzle_link_rx #(.swizzle_mode_p(1)) u_m1 (
    .clk_i(clk), .reset_i(rst), .port_v_i(pv[1]), .port_data_i(pd[1]),
    .port_tkn_o(tkn[1]), .v_o(vo[1]), .data_o(dout[1]), .ready_i(rdy[1]),
    .overflow_o(ovf[1]), .occupancy_o(occ[1]));

  bsg_chip_unswizzle_link_rx #(.swizzle_mode_p(2)) u_m2 (
    .clk_i(clk), .reset_i(rst), .port_v_i(pv[2]), .port_data_i(pd[2]),
    .port_tkn_o(tkn[2]), .v_o(vo[2]), .data_o(dout[2]), .ready_i(rdy[2]),
    .overflow_o(ovf[2]), .occupancy_o(occ[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pin map, written from the mode tables: returns {v, d[8:0]}.
  function automatic logic [9:0] model_unswizzle(input int mode, input logic v, input logic [8:0] p);
    logic [8:0] d;
    logic       lv;
    d  = '0;
    lv = 1'b0;
    if (mode == 1) begin
      d[4] = v;    d[6] = p[0]; d[5] = p[1]; d[7] = p[2]; d[8] = p[3];
      d[3] = p[4]; lv   = p[5]; d[2] = p[6]; d[1] = p[7]; d[0] = p[8];
    end else if (mode == 2) begin
      d[4] = v;    d[8] = p[0]; d[7] = p[1]; lv   = p[2]; d[6] = p[3];
      d[5] = p[4]; d[3] = p[5]; d[2] = p[6]; d[1] = p[7]; d[0] = p[8];
    end else begin
      lv = v;
      d  = p;
    end
    return {lv, d};
  endfunction

  task automatic push_exp(input int i, input logic [8:0] w);
    case (i)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [8:0] q_front(input int i);
    case (i)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_pop(input int i);
    case (i)
      0:       exp_q0.delete(0);
      1:       exp_q1.delete(0);
      default: exp_q2.delete(0);
    endcase
  endtask

  task automatic flush_sb();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < 3; i++) begin
      deq_cnt[i] = 0;
      exp_tkn[i] = 1'b0;
    end
  endtask

  // Driver: put a bundle on instance i's pins; push its word if it should land.
  task automatic set_pins(input int i, input logic v, input logic [8:0] d, input bit accept);
    logic [9:0] m;
    pv[i] = v;
    pd[i] = d;
    m = model_unswizzle(i, v, d);
    if (m[9] && accept) push_exp(i, m[8:0]);
  endtask

  task automatic drive(input int i, input logic v, input logic [8:0] d, input bit accept);
    @(posedge clk);
    #1;
    set_pins(i, v, d, accept);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: head word and token line are compared every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("tkn%0d", i), 32'(tkn[i]), 32'(exp_tkn[i]));
        if (vo[i]) begin
          if (q_size(i) == 0) begin
            check_eq($sformatf("unexpected_word%0d", i), 32'(vo[i]), 32'd0);
          end else begin
            check_eq($sformatf("data%0d", i), 32'(dout[i]), 32'(q_front(i)));
            if (rdy[i]) begin
              q_pop(i);
              deq_cnt[i]++;
              if (deq_cnt[i] % 4 == 0) exp_tkn[i] = ~exp_tkn[i];
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pv[i]  = 1'b0;
      pd[i]  = '0;
      rdy[i] = 1'b1;
    end
    flush_sb();
    wait_cycles(3);

    // Reset values on every instance
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_v%0d", i), 32'(vo[i]), 32'd0);
      check_eq($sformatf("rst_data%0d", i), 32'(dout[i]), 32'd0);
      check_eq($sformatf("rst_tkn%0d", i), 32'(tkn[i]), 32'd0);
      check_eq($sformatf("rst_ovf%0d", i), 32'(ovf[i]), 32'd0);
      check_eq($sformatf("rst_occ%0d", i), 32'(occ[i]), 32'd0);
    end
    rst = 1'b0;
    wait_cycles(10);
    check_eq("idle_v0", 32'(vo[0]), 32'd0);
    check_eq("idle_occ0", 32'(occ[0]), 32'd0);

    // Mode 1 directed word with latency check
    drive(1, 1'b1, 9'h020, 1'b1);
    wait_cycles(1);
    set_pins(1, 1'b0, 9'h000, 1'b0);
    check_eq("m1_early_v", 32'(vo[1]), 32'd0);
    wait_cycles(1);
    check_eq("m1_v", 32'(vo[1]), 32'd1);
    check_eq("m1_data", 32'(dout[1]), 32'h010);
    wait_cycles(3);

    // Mode 2 directed word
    drive(2, 1'b0, 9'h104, 1'b1);
    wait_cycles(1);
    set_pins(2, 1'b0, 9'h000, 1'b0);
    wait_cycles(1);
    check_eq("m2_v", 32'(vo[2]), 32'd1);
    check_eq("m2_data", 32'(dout[2]), 32'h001);
    wait_cycles(3);

    // Random bundles through modes 1 and 2
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      for (int i = 1; i < 3; i++)
        set_pins(i, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b1);
    end
    drive(1, 1'b0, 9'h000, 1'b0);
    set_pins(2, 1'b0, 9'h000, 1'b0);
    wait_cycles(6);
    check_eq("m1_drained", 32'(q_size(1)), 32'd0);
    check_eq("m2_drained", 32'(q_size(2)), 32'd0);

    // Credits: eight words streamed through mode 0
    for (int k = 1; k <= 8; k++) drive(0, 1'b1, 9'(k), 1'b1);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(6);
    check_eq("cred_deq", 32'(deq_cnt[0]), 32'd8);
    check_eq("cred_tkn", 32'(tkn[0]), 32'd0);
    check_eq("cred_occ", 32'(occ[0]), 32'd0);

    // Backpressure until full, then one overflowing word
    rdy[0] = 1'b0;
    for (int k = 1; k <= 8; k++) drive(0, 1'b1, 9'(k), 1'b1);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(3);
    check_eq("full_occ", 32'(occ[0]), 32'd8);
    check_eq("full_ovf", 32'(ovf[0]), 32'd0);
    check_eq("full_tkn", 32'(tkn[0]), 32'd0);
    drive(0, 1'b1, 9'h0aa, 1'b0);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(3);
    check_eq("ovf_set", 32'(ovf[0]), 32'd1);
    check_eq("ovf_occ", 32'(occ[0]), 32'd8);
    rdy[0] = 1'b1;
    wait_cycles(15);
    check_eq("bp_deq", 32'(deq_cnt[0]), 32'd16);
    check_eq("bp_occ", 32'(occ[0]), 32'd0);
    check_eq("ovf_sticky", 32'(ovf[0]), 32'd1);

    // Asynchronous reset with words buffered and token high
    for (int k = 1; k <= 4; k++) drive(0, 1'b1, 9'(9'h040 + k), 1'b1);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(8);
    check_eq("pre_rst_tkn", 32'(tkn[0]), 32'd1);
    rdy[0] = 1'b0;
    for (int k = 1; k <= 3; k++) drive(0, 1'b1, 9'(9'h050 + k), 1'b1);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(3);
    check_eq("pre_rst_occ", 32'(occ[0]), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_v", 32'(vo[0]), 32'd0);
    check_eq("arst_occ", 32'(occ[0]), 32'd0);
    check_eq("arst_tkn", 32'(tkn[0]), 32'd0);
    check_eq("arst_ovf", 32'(ovf[0]), 32'd0);
    check_eq("arst_data", 32'(dout[0]), 32'd0);
    flush_sb();
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(10);
    check_eq("post_rst_v", 32'(vo[0]), 32'd0);
    check_eq("post_rst_occ", 32'(occ[0]), 32'd0);

    // Full FIFO with enqueue and dequeue on the same edge
    for (int k = 1; k <= 8; k++) drive(0, 1'b1, 9'(9'h020 + k), 1'b1);
    drive(0, 1'b0, 9'h000, 1'b0);
    wait_cycles(3);
    check_eq("sim_full_occ", 32'(occ[0]), 32'd8);
    drive(0, 1'b1, 9'h029, 1'b1);
    wait_cycles(1);
    set_pins(0, 1'b0, 9'h000, 1'b0);
    rdy[0] = 1'b1;
    wait_cycles(1);
    rdy[0] = 1'b0;
    check_eq("sim_occ", 32'(occ[0]), 32'd8);
    check_eq("sim_ovf", 32'(ovf[0]), 32'd0);
    rdy[0] = 1'b1;
    wait_cycles(15);
    check_eq("sim_deq", 32'(deq_cnt[0]), 32'd9);
    check_eq("sim_drained_occ", 32'(occ[0]), 32'd0);

    for (int i = 0; i < 3; i++)
      check_eq($sformatf("q_empty%0d", i), 32'(q_size(i)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
